// File: rtl/div_sequencer.sv
// div_sequencer: issue/retire sequencer between the Ex stage and the unsigned multi-cycle divide core
module div_sequencer #(
  parameter int XLEN = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic [6:0]            ReqOpCode,
  input  logic [2:0]            ReqFunct3,
  input  logic [XLEN-1:0]       ReqDividend,
  input  logic [XLEN-1:0]       ReqDivisor,
  input  logic [REG_ADDR_W-1:0] ReqWriteAddr,
  input  logic                  Flush,
  output logic                  CoreStart,
  output logic                  CoreKill,
  output logic [XLEN-1:0]       CoreDividend,
  output logic [XLEN-1:0]       CoreDivisor,
  input  logic                  CoreDone,
  input  logic [XLEN-1:0]       CoreQuotient,
  input  logic [XLEN-1:0]       CoreRemainder,
  output logic                  RspValid,
  input  logic                  RspReady,
  output logic [XLEN-1:0]       RspData,
  output logic [REG_ADDR_W-1:0] RspWriteAddr,
  output logic                  HoldFlag
);
  localparam logic [6:0] OP64 = 7'b0110011;
  localparam logic [6:0] OPW = 7'b0111011;
  typedef enum logic [1:0] {IDLE, SPECIAL, BUSY, RESP} stateT;
  stateT state, nextState;
  logic reqW, reqSigned, reqNegA, reqNegB, div0, ovf, special, reqFire;
  logic isW, isRem, negA, negB;
  logic [XLEN-1:0] opA, opB, magA, magB, minVal, specialRes, quot, rem, fixRes;

  function automatic logic [XLEN-1:0] wExt(input logic [XLEN-1:0] v, input logic w);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Operand preparation and local resolution of divide-by-zero / signed overflow
  always_comb begin
    reqW = ReqOpCode == OPW;
    reqSigned = !ReqFunct3[0];
    opA = reqW ? {{(XLEN-32){reqSigned & ReqDividend[31]}}, ReqDividend[31:0]} : ReqDividend;
    opB = reqW ? {{(XLEN-32){reqSigned & ReqDivisor[31]}}, ReqDivisor[31:0]} : ReqDivisor;
    reqNegA = reqSigned & opA[XLEN-1];
    reqNegB = reqSigned & opB[XLEN-1];
    magA = reqNegA ? -opA : opA;
    magB = reqNegB ? -opB : opB;
    minVal = reqW ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    div0 = opB == {XLEN{1'b0}};
    ovf = reqSigned && (opA == minVal) && (&opB);
    special = div0 || ovf;
    specialRes = wExt(div0 ? (ReqFunct3[1] ? opA : {XLEN{1'b1}}) : (ReqFunct3[1] ? {XLEN{1'b0}} : opA), reqW);
    reqFire = (state == IDLE) && ReqValid && (ReqOpCode == OP64 || reqW) && ReqFunct3[2] && !Flush;
  end

  // Sign fix-up of the unsigned core result
  always_comb begin
    quot = (negA ^ negB) ? -CoreQuotient : CoreQuotient;
    rem = negA ? -CoreRemainder : CoreRemainder;
    fixRes = wExt(isRem ? rem : quot, isW);
  end

  // Next state and handshake outputs; flush overrides every transition
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = reqFire ? (special ? SPECIAL : BUSY) : IDLE;
      SPECIAL: nextState = RESP;
      BUSY:    nextState = CoreDone ? RESP : BUSY;
      RESP:    nextState = RspReady ? IDLE : RESP;
      default: nextState = IDLE;
    endcase
    if (Flush) nextState = IDLE;
    ReqReady = state == IDLE;
    RspValid = state == RESP;
    HoldFlag = (state != IDLE) || reqFire;
    CoreKill = Flush && (state == BUSY);
  end

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else state <= nextState;
  end

  // Request capture, core launch and result holding
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      CoreStart <= 1'b0;
      CoreDividend <= '0;
      CoreDivisor <= '0;
      RspData <= '0;
      RspWriteAddr <= '0;
      isW <= 1'b0;
      isRem <= 1'b0;
      negA <= 1'b0;
      negB <= 1'b0;
    end else begin
      CoreStart <= reqFire && !special;
      if (reqFire) begin
        CoreDividend <= magA;
        CoreDivisor <= magB;
        RspData <= specialRes;
        RspWriteAddr <= ReqWriteAddr;
        isW <= reqW;
        isRem <= ReqFunct3[1];
        negA <= reqNegA;
        negB <= reqNegB;
      end else if (state == BUSY && CoreDone && !Flush) begin
        RspData <= fixRes;
      end
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: randomized self-checking bench with an arithmetic reference model
module tb_div_sequencer;
  localparam logic [6:0] OP64 = 7'b0110011;
  localparam logic [6:0] OPW = 7'b0111011;
  logic Clk = 1'b0;
  logic Rst, ReqValid, ReqReady, Flush, CoreStart, CoreKill, CoreDone, RspValid, RspReady, HoldFlag;
  logic [6:0] ReqOpCode;
  logic [2:0] ReqFunct3;
  logic [63:0] ReqDividend, ReqDivisor, CoreDividend, CoreDivisor, CoreQuotient, CoreRemainder, RspData;
  logic [4:0] ReqWriteAddr, RspWriteAddr;
  int checks = 0;
  int failures = 0;

  div_sequencer dut (
    .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOpCode(ReqOpCode),
    .ReqFunct3(ReqFunct3), .ReqDividend(ReqDividend), .ReqDivisor(ReqDivisor),
    .ReqWriteAddr(ReqWriteAddr), .Flush(Flush), .CoreStart(CoreStart), .CoreKill(CoreKill),
    .CoreDividend(CoreDividend), .CoreDivisor(CoreDivisor), .CoreDone(CoreDone),
    .CoreQuotient(CoreQuotient), .CoreRemainder(CoreRemainder), .RspValid(RspValid),
    .RspReady(RspReady), .RspData(RspData), .RspWriteAddr(RspWriteAddr), .HoldFlag(HoldFlag)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic smp;
    @(negedge Clk);
  endtask

  // RISC-V M-extension semantics plus the magnitudes the core should see
  task automatic refModel(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output logic [63:0] ma, output logic [63:0] mb, output logic sp);
    logic w, sgn, rm;
    int a32, b32;
    longint sa, sb, minv, sr;
    logic [63:0] ua, ub, ur;
    w = op == OPW;
    sgn = !f3[0];
    rm = f3[1];
    a32 = a[31:0];
    b32 = b[31:0];
    if (sgn) begin
      sa = w ? longint'(a32) : longint'(a);
      sb = w ? longint'(b32) : longint'(b);
      minv = w ? -64'sd2147483648 : {1'b1, 63'b0};
      sp = (sb == 0) || (sa == minv && sb == -1);
      if (sb == 0) sr = rm ? sa : -1;
      else if (sa == minv && sb == -1) sr = rm ? 0 : sa;
      else sr = rm ? sa % sb : sa / sb;
      ur = sr;
      ma = sa < 0 ? -sa : sa;
      mb = sb < 0 ? -sb : sb;
    end else begin
      ua = w ? {32'b0, a[31:0]} : a;
      ub = w ? {32'b0, b[31:0]} : b;
      sp = ub == 0;
      if (ub == 0) ur = rm ? ua : {64{1'b1}};
      else ur = rm ? ua % ub : ua / ub;
      ma = ua;
      mb = ub;
    end
    res = w ? {{32{ur[31]}}, ur[31:0]} : ur;
  endtask

  function automatic logic [63:0] pickVal();
    logic [63:0] v;
    longint t;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = 64'd1;
      2: v = {64{1'b1}};
      3: v = {1'b1, 63'b0};
      4: v = 64'h0000_0000_8000_0000;
      5: v = 64'h0000_0000_FFFF_FFFF;
      6: begin
        t = longint'($urandom_range(0, 40)) - 20;
        v = t;
      end
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic runOp(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input int dly, input int stall);
    logic [63:0] exp, ma, mb;
    logic sp;
    refModel(op, f3, a, b, exp, ma, mb, sp);
    tick;
    ReqValid = 1'b1; ReqOpCode = op; ReqFunct3 = f3; ReqDividend = a; ReqDivisor = b; ReqWriteAddr = rd;
    smp;
    check("accept_ready", ReqReady, 1);
    check("accept_hold", HoldFlag, 1);
    tick;
    ReqValid = 1'b0; ReqDividend = {$urandom, $urandom}; ReqDivisor = {$urandom, $urandom}; ReqWriteAddr = 5'($urandom);
    smp;
    check("core_start", CoreStart, !sp);
    if (sp) begin
      check("special_wait", RspValid, 0);
      tick;
      smp;
    end else begin
      check("core_dividend", CoreDividend, ma);
      check("core_divisor", CoreDivisor, mb);
      repeat (dly) begin
        tick;
        smp;
        check("busy_quiet", {CoreStart, RspValid, HoldFlag}, 3'b001);
      end
      tick;
      CoreDone = 1'b1; CoreQuotient = ma / mb; CoreRemainder = ma % mb;
      smp;
      check("done_wait", RspValid, 0);
      tick;
      CoreDone = 1'b0; CoreQuotient = {$urandom, $urandom}; CoreRemainder = {$urandom, $urandom};
      smp;
    end
    check("rsp_valid", RspValid, 1);
    check("rsp_data", RspData, exp);
    check("rsp_addr", RspWriteAddr, rd);
    repeat (stall) begin
      tick;
      smp;
      check("stall_valid", RspValid, 1);
      check("stall_data", RspData, exp);
    end
    tick;
    RspReady = 1'b1;
    smp;
    check("hs_valid", RspValid, 1);
    tick;
    RspReady = 1'b0;
    smp;
    check("released", RspValid, 0);
    check("ready_again", ReqReady, 1);
  endtask

  task automatic launch(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    tick;
    ReqValid = 1'b1; ReqOpCode = OP64; ReqFunct3 = f3; ReqDividend = a; ReqDivisor = b; ReqWriteAddr = 5'd9;
    smp;
    tick;
    ReqValid = 1'b0;
  endtask

  initial begin
    Rst = 1'b0; ReqValid = 1'b0; ReqOpCode = '0; ReqFunct3 = '0; ReqDividend = '0; ReqDivisor = '0;
    ReqWriteAddr = '0; Flush = 1'b0; CoreDone = 1'b0; CoreQuotient = '0; CoreRemainder = '0; RspReady = 1'b0;
    smp;
    check("rst_ready", ReqReady, 1);
    check("rst_outs", {RspValid, CoreStart, CoreKill, HoldFlag}, 0);
    check("rst_data", RspData, 0);
    tick;
    Rst = 1'b1;
    runOp(OP64, 3'b100, -64'd7, 64'd2, 5'd1, 2, 0);
    runOp(OP64, 3'b110, -64'd7, 64'd2, 5'd2, 1, 0);
    runOp(OP64, 3'b101, 64'h1234, 64'd0, 5'd3, 0, 0);
    runOp(OPW, 3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 5'd4, 0, 1);
    runOp(OPW, 3'b111, 64'h1_0000_0007, 64'd2, 5'd5, 1, 3);
    launch(3'b100, 64'd100, 64'd7);
    smp;
    check("flush_pre_start", CoreStart, 1);
    tick;
    smp;
    tick;
    Flush = 1'b1;
    smp;
    check("flush_kill", CoreKill, 1);
    tick;
    Flush = 1'b0;
    smp;
    check("flush_kill_once", CoreKill, 0);
    check("flush_idle", {ReqReady, HoldFlag}, 2'b10);
    tick;
    CoreDone = 1'b1;
    smp;
    tick;
    CoreDone = 1'b0;
    smp;
    check("late_done", RspValid, 0);
    check("late_done_ready", ReqReady, 1);
    launch(3'b101, 64'd50, 64'd3);
    Flush = 1'b1;
    smp;
    check("flush_start_kill", CoreKill, 1);
    tick;
    Flush = 1'b0;
    smp;
    check("flush_start_idle", {ReqReady, CoreKill, CoreStart}, 3'b100);
    tick;
    ReqValid = 1'b1; Flush = 1'b1; ReqFunct3 = 3'b100; ReqDividend = 64'd9; ReqDivisor = 64'd3;
    smp;
    tick;
    ReqValid = 1'b0; Flush = 1'b0;
    smp;
    check("flush_accept", {CoreStart, ReqReady, HoldFlag}, 3'b010);
    tick;
    ReqValid = 1'b1; ReqOpCode = OP64; ReqFunct3 = 3'b000;
    smp;
    check("bad_f3_hold", {ReqReady, HoldFlag}, 2'b10);
    tick;
    ReqOpCode = 7'b0010011; ReqFunct3 = 3'b100;
    smp;
    check("bad_op_hold", {ReqReady, HoldFlag}, 2'b10);
    tick;
    ReqValid = 1'b0;
    smp;
    check("bad_op_idle", {ReqReady, CoreStart}, 2'b10);
    tick;
    CoreDone = 1'b1;
    smp;
    tick;
    CoreDone = 1'b0;
    smp;
    check("idle_done", {RspValid, HoldFlag}, 0);
    launch(3'b101, 64'd5, 64'd0);
    smp;
    tick;
    smp;
    check("resp_before_flush", RspValid, 1);
    tick;
    Flush = 1'b1;
    smp;
    tick;
    Flush = 1'b0;
    smp;
    check("resp_flush", {RspValid, ReqReady}, 2'b01);
    launch(3'b100, 64'd100, 64'd7);
    smp;
    tick;
    Rst = 1'b0;
    smp;
    check("mid_reset", {ReqReady, CoreKill, HoldFlag, CoreStart}, 4'b1000);
    tick;
    Rst = 1'b1;
    for (int i = 0; i < 300; i++)
      runOp($urandom_range(0, 1) ? OPW : OP64, 3'(4 + $urandom_range(0, 3)), pickVal(), pickVal(),
            5'($urandom), $urandom_range(0, 4), $urandom_range(0, 2));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
